// File: rtl/in_port_fifo_if.sv
// Signal bundle between the CPU/device side and the multi-channel input port.
// The tri-state bus output is kept as a separate net on the port module.
interface in_port_fifo_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
);
  logic [CHANNELS*WIDTH-1:0] iData;
  logic [CHANNELS-1:0]       iStrobe;
  logic [SEL_W-1:0]          iSel;
  logic                      iEnable;
  logic                      iPop;
  logic                      iClrOvf;
  logic [CHANNELS-1:0]       oReady;
  logic [CHANNELS-1:0]       oFull;
  logic [CHANNELS-1:0]       oOverflow;

  modport master (
    output iData, iStrobe, iSel, iEnable, iPop, iClrOvf,
    input  oReady, oFull, oOverflow
  );

  modport slave (
    input  iData, iStrobe, iSel, iEnable, iPop, iClrOvf,
    output oReady, oFull, oOverflow
  );
endinterface

// File: rtl/in_port_fifo.sv
// Multi-channel buffered input port. Each channel captures device data on a
// strobe into its own small FIFO; the CPU selects a channel and drives that
// channel's oldest byte onto the shared tri-state bus, optionally popping it.
module in_port_fifo #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  parameter int SEL_W    = 1
) (
  input  logic              iClk,
  input  logic              iRstN,
  in_port_fifo_if.slave     bus,
  output tri  [WIDTH-1:0]   oData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

  logic [WIDTH-1:0]    mem_r    [CHANNELS][DEPTH];
  logic [AW-1:0]       wr_ptr_r [CHANNELS];
  logic [AW-1:0]       rd_ptr_r [CHANNELS];
  logic [AW:0]         count_r  [CHANNELS];
  logic [CHANNELS-1:0] ovf_r;

  logic [CHANNELS-1:0] push_s;
  logic [CHANNELS-1:0] pop_s;
  logic [CHANNELS-1:0] ovf_set_s;
  logic [CHANNELS-1:0] ready_s;
  logic [CHANNELS-1:0] full_s;
  logic                sel_valid_s;
  logic                drive_s;
  logic [WIDTH-1:0]    bus_data_s;

  // Per-channel push/pop/overflow decisions and status derived from counts.
  always_comb begin
    push_s      = {CHANNELS{1'b0}};
    pop_s       = {CHANNELS{1'b0}};
    ovf_set_s   = {CHANNELS{1'b0}};
    ready_s     = {CHANNELS{1'b0}};
    full_s      = {CHANNELS{1'b0}};
    sel_valid_s = (int'(bus.iSel) < CHANNELS);
    for (int c = 0; c < CHANNELS; c++) begin
      ready_s[c] = (count_r[c] != ZERO_CNT);
      full_s[c]  = (count_r[c] == FULL_CNT);
      // A pop from an empty channel is ignored, so a same-edge push on an
      // empty channel simply goes 0 -> 1.
      pop_s[c]   = bus.iEnable && bus.iPop && sel_valid_s &&
                   (int'(bus.iSel) == c) && ready_s[c];
      // A pop on the same edge frees a slot, so a full channel still accepts.
      push_s[c]    = bus.iStrobe[c] && (!full_s[c] || pop_s[c]);
      ovf_set_s[c] = bus.iStrobe[c] && full_s[c] && !pop_s[c];
    end
  end

  // Head-of-FIFO mux for the selected channel; empty channel reads as zero.
  always_comb begin
    bus_data_s = {WIDTH{1'b0}};
    drive_s    = iRstN && bus.iEnable && sel_valid_s;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((int'(bus.iSel) == c) && ready_s[c]) begin
        bus_data_s = mem_r[c][rd_ptr_r[c]];
      end else begin
        bus_data_s = bus_data_s;
      end
    end
  end

  // FIFO storage write; contents need no reset since counts gate every read.
  always_ff @(posedge iClk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= bus.iData[c*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_r[c] <= {AW{1'b0}};
        rd_ptr_r[c] <= {AW{1'b0}};
        count_r[c]  <= ZERO_CNT;
      end
      ovf_r <= {CHANNELS{1'b0}};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (push_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1'b1);
        end
        if (pop_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1'b1);
        end
        case ({push_s[c], pop_s[c]})
          2'b10:   count_r[c] <= count_r[c] + (AW+1)'(1'b1);
          2'b01:   count_r[c] <= count_r[c] - (AW+1)'(1'b1);
          default: count_r[c] <= count_r[c];
        endcase
      end
      // Clear applies to all channels; a new overflow on the same edge wins.
      ovf_r <= (bus.iClrOvf ? {CHANNELS{1'b0}} : ovf_r) | ovf_set_s;
    end
  end

  assign bus.oReady    = ready_s;
  assign bus.oFull     = full_s;
  assign bus.oOverflow = ovf_r;
  assign oData         = drive_s ? bus_data_s : {WIDTH{1'bz}};

endmodule

// File: tb/tb_in_port_fifo.sv
// Directed bench for in_port_fifo (2 channels, depth 4). The bus net is a
// pulled-up net, so an undriven (high-Z) bus reads as 8'hFF.
module tb_in_port_fifo;

  localparam logic [7:0] BUS_Z = 8'hFF;

  logic iClk;
  logic iRstN;
  tri1 [7:0] odata;

  in_port_fifo_if #(.WIDTH(8), .CHANNELS(2), .SEL_W(1)) bus_if ();

  in_port_fifo #(.WIDTH(8), .CHANNELS(2), .DEPTH(4), .SEL_W(1)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus_if),
    .oData (odata)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sel;
    logic       en;
    logic       pop;
    logic       clr;
    logic [1:0] rdy;
    logic [1:0] full;
    logic [1:0] ovf;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];
  int checks;
  int errors;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic [7:0] d0, input logic [7:0] d1,
                       input logic sel, input logic en, input logic pop, input logic clr);
    bus_if.iStrobe = st;
    bus_if.iData   = {d1, d0};
    bus_if.iSel    = sel;
    bus_if.iEnable = en;
    bus_if.iPop    = pop;
    bus_if.iClrOvf = clr;
  endtask

  task automatic step(input logic [1:0] st, input logic [7:0] d0, input logic [7:0] d1,
                      input logic sel, input logic en, input logic pop, input logic clr);
    drive(st, d0, d1, sel, en, pop, clr);
    @(posedge iClk);
    #1;
  endtask

  task automatic add(input string name, input logic [1:0] st, input logic [7:0] d0,
                     input logic [7:0] d1, input logic sel, input logic en, input logic pop,
                     input logic clr, input logic [1:0] rdy, input logic [1:0] full,
                     input logic [1:0] ovf, input logic [7:0] dat);
    vecs.push_back('{name, st, d0, d1, sel, en, pop, clr, rdy, full, ovf, dat});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    iRstN  = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Ordering and pointer wrap on ch0
    add("ord_push11", 2'b01, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h11);
    add("ord_push22", 2'b01, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h11);
    add("ord_push33", 2'b01, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h11);
    add("ord_push44", 2'b01, 8'h44, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 8'h11);
    add("ord_pop1",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h22);
    add("ord_pop2",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h33);
    add("ord_push55", 2'b01, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h33);
    add("ord_push66", 2'b01, 8'h66, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 8'h33);
    add("ord_pop3",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h44);
    add("ord_pop4",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h55);
    add("ord_pop5",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h66);
    add("ord_pop6",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
    // Full channel with simultaneous push and pop
    add("pp_fill01",  2'b01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h01);
    add("pp_fill02",  2'b01, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h01);
    add("pp_fill03",  2'b01, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h01);
    add("pp_fill04",  2'b01, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 8'h01);
    add("pp_full_pp", 2'b01, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 8'h02);
    add("pp_rd03",    2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h03);
    add("pp_rd04",    2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h04);
    add("pp_rd05",    2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h05);
    add("pp_drain",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
    add("pp_empty_pp",2'b01, 8'h77, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h77);
    add("pp_drain2",  2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
    // Concurrent channels
    add("cc_push",    2'b11, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 8'h34);
    add("cc_pop_ch1", 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 8'h00);
    add("cc_rd_ch0",  2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 8'h12);
    add("cc_pop_ch0", 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
    // Bus isolation
    add("iso_push_z", 2'b11, 8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, BUS_Z);
    add("iso_sel0",   2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 8'h5A);
    add("iso_sel1",   2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 8'hC3);
    add("iso_pop_dis",2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, BUS_Z);
    add("iso_keep0",  2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 8'h5A);
    add("iso_keep1",  2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 8'hC3);
    add("iso_drain0", 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 8'h00);
    add("iso_drain1", 2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
    // Overflow on ch1
    add("ov_fillA0",  2'b10, 8'h00, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 8'hA0);
    add("ov_fillA1",  2'b10, 8'h00, 8'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 8'hA0);
    add("ov_fillA2",  2'b10, 8'h00, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 8'hA0);
    add("ov_fillA3",  2'b10, 8'h00, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 8'hA0);
    add("ov_dropFF",  2'b10, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 8'hA0);
    add("ov_clear",   2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 8'hA0);
    add("ov_setwins", 2'b10, 8'h00, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b10, 8'hA0);
    add("ov_rdA1",    2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'hA1);
    add("ov_rdA2",    2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'hA2);
    add("ov_rdA3",    2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 8'hA3);
    add("ov_drain",   2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 8'h00);
    add("ov_clear2",  2'b00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 8'h00);

    // Initial reset, bus enabled throughout
    repeat (2) @(posedge iClk);
    #1;
    chk("rst0_ready", {6'b0, bus_if.oReady},    8'h00);
    chk("rst0_full",  {6'b0, bus_if.oFull},     8'h00);
    chk("rst0_ovf",   {6'b0, bus_if.oOverflow}, 8'h00);
    chk("rst0_bus_z", odata, BUS_Z);
    #3;
    iRstN = 1'b1;
    #1;
    chk("rst0_bus_after", odata, 8'h00);

    @(posedge iClk);
    #1;
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].d0, vecs[i].d1, vecs[i].sel, vecs[i].en, vecs[i].pop, vecs[i].clr);
      chk({vecs[i].name, "_ready"}, {6'b0, bus_if.oReady},    {6'b0, vecs[i].rdy});
      chk({vecs[i].name, "_full"},  {6'b0, bus_if.oFull},     {6'b0, vecs[i].full});
      chk({vecs[i].name, "_ovf"},   {6'b0, bus_if.oOverflow}, {6'b0, vecs[i].ovf});
      chk({vecs[i].name, "_bus"},   odata, vecs[i].dat);
    end

    // Reset mid-operation: ch0 holds 3 entries, ch1 full with overflow set
    step(2'b11, 8'h11, 8'hB0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b11, 8'h22, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b11, 8'h33, 8'hB2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b10, 8'h00, 8'hB3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(2'b10, 8'h00, 8'hB4, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_ready", {6'b0, bus_if.oReady},    8'h03);
    chk("pre_rst_ovf",   {6'b0, bus_if.oOverflow}, 8'h02);
    chk("pre_rst_bus",   odata, 8'h11);
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    iRstN = 1'b0;
    #1;
    chk("rst_ready", {6'b0, bus_if.oReady},    8'h00);
    chk("rst_full",  {6'b0, bus_if.oFull},     8'h00);
    chk("rst_ovf",   {6'b0, bus_if.oOverflow}, 8'h00);
    chk("rst_bus_z", odata, BUS_Z);
    // A strobe while held in reset must not be captured
    step(2'b01, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_hold_ready", {6'b0, bus_if.oReady}, 8'h00);
    chk("rst_hold_bus_z", odata, BUS_Z);
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #3;
    iRstN = 1'b1;
    #1;
    chk("rst_rel_bus",   odata, 8'h00);
    chk("rst_rel_ready", {6'b0, bus_if.oReady}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/in_port_fifo.md
Name: in_port_fifo

Overview:
- Parametrised multi-channel input port for the SAP-2 datapath; successor to the single-channel tri-state input buffer.
- Each channel captures external device data on a strobe into a small FIFO, so the device does not have to hold data until the CPU reads it.
- The CPU selects a channel and drives its oldest byte onto the shared tri-state bus.
- Adds per-channel buffering, ready/full/overflow status and a pop handshake.

Parameters:
- WIDTH, 8, data width of each channel and of the bus.
- CHANNELS, 2, number of independent input channels (at least 1).
- DEPTH, 4, FIFO entries per channel (power of 2, at least 2).
- SEL_W, 1, width of the channel select (2**SEL_W at least CHANNELS).

Ports:
- iClk  input  1  system clock; all state changes on the rising edge.
- iRstN  input  1  asynchronous active-low reset.
- iData  input  CHANNELS*WIDTH  external device data; channel c occupies bits [c*WIDTH +: WIDTH].
- iStrobe  input  CHANNELS  per-channel write request, sampled at the rising edge.
- iSel  input  SEL_W  channel selected for bus read.
- iEnable  input  1  bus output enable (CPU IN-instruction control signal).
- iPop  input  1  consume the selected channel's head entry at the next edge (valid only with iEnable).
- iClrOvf  input  1  clear all overflow flags.
- oData  output (tri)  WIDTH  shared bus output.
- oReady  output  CHANNELS  channel FIFO non-empty.
- oFull  output  CHANNELS  channel FIFO holds DEPTH entries.
- oOverflow  output  CHANNELS  sticky flag: a strobe arrived while the channel was full.

Behaviour:
- Per-channel state: write pointer, read pointer (log2(DEPTH) bits each, wrapping modulo DEPTH), and occupancy count (log2(DEPTH)+1 bits).
- Reset (iRstN=0, asynchronous):
  - pointers and counts go to 0; oOverflow=0; oReady=0; oFull=0.
  - oData is high-Z for the whole reset duration, regardless of iEnable.
- Push: at the edge, if iStrobe[c]=1 and count<DEPTH, the channel-c slice of iData is written at the write pointer and the write pointer increments.
  - If count==DEPTH and no pop to c occurs that edge, the data is dropped and oOverflow[c] is set.
- Pop: at the edge, if iEnable=1, iPop=1, iSel<CHANNELS and the selected count>0, the read pointer of channel iSel increments.
  - iPop with iEnable=0, with an empty channel, or with an out-of-range iSel is ignored; no state change.
- Simultaneous push and pop on one channel:
  - count unchanged; both pointers advance.
  - When full, the push is accepted (no overflow) because the pop frees a slot.
  - When empty, the pop is ignored and the push is accepted (count 0 to 1).
- Bus drive (combinational):
  - iEnable=1 and iSel<CHANNELS: oData = head entry of channel iSel when its count>0, else 0 (the bus is always defined while enabled).
  - iEnable=0 or iSel>=CHANNELS: oData is high-Z.
- Latency:
  - A byte pushed at edge N is visible on oData (if selected and at the head) immediately after edge N.
  - oReady and oFull update after the same edge.
- Status outputs: oReady[c] = (count!=0); oFull[c] = (count==DEPTH). Both are registered-state derived, with no combinational path from iStrobe or iPop.
- Overflow flags:
  - iClrOvf=1 at an edge clears all oOverflow bits.
  - If a new overflow occurs on the same edge, that channel's bit is set (set wins).
- Channels are fully independent; strobes on multiple channels in the same cycle are all accepted.
- Pointer wrap: after DEPTH pushes and DEPTH pops, the pointers return to 0 and FIFO order is preserved across the wrap.

Test Plan:
1. Reset then idle: iRstN low mid-operation with 3 entries in ch0 -> all counts 0, oReady=00, oOverflow=00, oData=Z even with iEnable=1 during reset; after release with iEnable=1, iSel=0 -> oData=0x00.
2. Ordering and wrap: push 0x11,0x22,0x33,0x44 on ch0 -> oFull[0]=1. Pop twice, push 0x55,0x66, then pop all -> oData sequence 0x11,0x22,0x33,0x44,0x55,0x66; oReady[0]=0 at end.
3. Overflow: fill ch1 with 0xA0..0xA3, strobe 0xFF -> oOverflow[1]=1 and 0xFF is never read. iClrOvf pulse -> flag 0. iClrOvf and another full-channel strobe on the same edge -> flag 1.
4. Full with simultaneous push/pop: ch0 full with 0x01..0x04, same edge push 0x05 and pop -> count stays 4, no overflow, subsequent reads 0x02,0x03,0x04,0x05.
5. Bus isolation: iEnable=0 -> oData=Z. iSel=0 with ch0 holding 0x5A while ch1 holds 0xC3 -> 0x5A; iSel=1 -> 0xC3. Pop with iEnable=0 -> counts unchanged.
6. Concurrent channels: same-edge strobes ch0=0x12 and ch1=0x34 -> oReady=11. Pop ch1 only -> ch0 still reads 0x12 and ch1 becomes empty.
